gcd_request_sequencer: RTL

- Initiator side of the Greatest_Common_Divisor start/done handshake.
- Accepts operand pairs from an upstream valid/ready stream and buffers them in a small FIFO.
- Issues each pair to the GCD unit with a one-cycle start pulse and waits for done.
- Returns {a, b, gcd, timeout} on a downstream valid/ready stream; sits between the lab's stimulus/keypad logic and the GCD core.

---
 rtl/gcd_pkg.sv | 20 ++
 rtl/gcd_req_fifo.sv | 50 +++++
 rtl/gcd_request_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and defaults for the GCD request sequencer
package gcd_pkg;

  localparam int GCD_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } gcd_state_t;

  typedef struct packed {
    logic [GCD_WIDTH-1:0] a;
    logic [GCD_WIDTH-1:0] b;
    logic [GCD_WIDTH-1:0] gcd;
    logic                 timeout;
  } gcd_result_t;

endpackage

// File: rtl/gcd_req_fifo.sv
// rtl/gcd_req_fifo.sv - operand-pair FIFO with registered count and async active-low reset
module gcd_req_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/gcd_request_sequencer.sv
// rtl/gcd_request_sequencer.sv - buffers operand pairs, drives the GCD start/done handshake, returns results
module gcd_request_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_timeout,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  gcd_state_t             state_q;
  gcd_state_t             state_d;
  logic [CW-1:0]          cnt_q;
  logic                   pop;
  logic                   capture;
  logic                   timed_out;
  logic [2*WIDTH-1:0]     fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [WIDTH-1:0]       head_a;
  logic [WIDTH-1:0]       head_b;

  gcd_req_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_a, head_b} = fifo_rdata;
  assign in_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Done takes priority over the timeout when both land on the same edge.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    gcd_start = 1'b0;
    capture   = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        gcd_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (gcd_done) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          capture   = 1'b1;
          timed_out = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcd_a       <= '0;
      gcd_b       <= '0;
      cnt_q       <= '0;
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_gcd     <= '0;
      out_timeout <= 1'b0;
    end else begin
      if (pop) begin
        gcd_a <= head_a;
        gcd_b <= head_b;
        cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture) begin
        out_a       <= gcd_a;
        out_b       <= gcd_b;
        out_gcd     <= timed_out ? '0 : gcd_result;
        out_timeout <= timed_out;
        out_valid   <= 1'b1;
      end else if (state_q == ST_HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
